// File: rtl/button_debouncer_pkg.sv
// Shared game constants: sample strobe rate and the default debounce window.
package button_debouncer_pkg;

  localparam int TICK_HZ              = 500;
  localparam int DEFAULT_STABLE_TICKS = 10;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, LOW/HIGH state
// machine and registered level / press / release outputs.
module debounce_channel #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int                CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             sync;

  assign sync = sync_q[1];

  // A change is accepted only on the STABLE_TICKS-th consecutive disagreeing
  // tick; any agreeing tick throws away the accumulated progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state  <= LOW;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      rel    <= 1'b0;
      if (tick) begin
        case (state)
          LOW: begin
            if (!sync)             cnt <= '0;
            else if (cnt == LAST) begin
              state <= HIGH;
              level <= 1'b1;
              press <= 1'b1;
              cnt   <= '0;
            end else               cnt <= cnt + CNT_W'(1);
          end
          HIGH: begin
            if (sync)              cnt <= '0;
            else if (cnt == LAST) begin
              state <= LOW;
              level <= 1'b0;
              rel   <= 1'b1;
              cnt   <= '0;
            end else               cnt <= cnt + CNT_W'(1);
          end
          default: state <= LOW;
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer sampled on the game's 500 Hz strobe.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_500hz,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (clk_500hz),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed + random bench for button_debouncer against a run-length model.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_500hz = 1'b0;
  logic [3:0] btn_raw = 4'h0;
  logic [3:0] lvl_a, prs_a, rel_a;
  logic [3:0] lvl_b, prs_b, rel_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  button_debouncer #(.NUM_BTN(4), .STABLE_TICKS(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_500hz(clk_500hz), .btn_raw(btn_raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a)
  );

  button_debouncer #(.NUM_BTN(4), .STABLE_TICKS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_500hz(1'b1), .btn_raw(btn_raw),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
  );

  // Model: h1 is the raw value seen two edges ago (what the channel samples),
  // run is the count of consecutive disagreeing ticks per channel.
  typedef struct packed {
    logic [3:0]      lvl;
    logic [3:0]      pr;
    logic [3:0]      rl;
    logic [3:0]      h0;
    logic [3:0]      h1;
    logic [3:0][8:0] run;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t mstep(mdl_t m, logic [3:0] raw, logic tick, int st);
    mdl_t       n = m;
    logic [3:0] s = m.h1;
    n.h1 = m.h0;
    n.h0 = raw;
    n.pr = '0;
    n.rl = '0;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] == m.lvl[i]) n.run[i] = '0;
        else if (int'(m.run[i]) + 1 == st) begin
          n.lvl[i] = s[i];
          n.pr[i]  = s[i];
          n.rl[i]  = ~s[i];
          n.run[i] = '0;
        end else n.run[i] = m.run[i] + 9'd1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_level",   lvl_a, ma.lvl);
    chk("a_press",   prs_a, ma.pr);
    chk("a_release", rel_a, ma.rl);
    chk("b_level",   lvl_b, mb.lvl);
    chk("b_press",   prs_b, mb.pr);
    chk("b_release", rel_b, mb.rl);
  endtask

  // One clk edge with given inputs; inputs change 1 time unit after an edge.
  task automatic step(input logic [3:0] raw, input logic tick);
    btn_raw   = raw;
    clk_500hz = tick;
    @(posedge clk);
    if (!rst_n) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = mstep(ma, raw, tick, 10);
      mb = mstep(mb, raw, 1'b1, 1);
    end
    #1;
    check_all();
  endtask

  // n sample ticks, one tick every `period` clocks.
  task automatic ticks(input logic [3:0] raw, input int n, input int period);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < period - 1; c++) step(raw, 1'b0);
      step(raw, 1'b1);
    end
  endtask

  // Reset asserted between clock edges must clear outputs without an edge.
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    ma = '0;
    mb = '0;
    check_all();
    for (int k = 0; k < hold; k++) step(btn_raw, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int p_cnt;
    // Reset held with all buttons down.
    #1;
    for (int k = 0; k < 4; k++) step(4'hF, 1'b1);
    rst_n = 1'b1;
    // Held through reset: press on the 10th tick, counted explicitly.
    p_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      for (int c = 0; c < 7; c++) step(4'hF, 1'b0);
      step(4'hF, 1'b1);
      if (prs_a == 4'hF) p_cnt++;
    end
    chk("held_press_count", 4'(p_cnt), 4'd1);
    chk("held_level", lvl_a, 4'hF);

    // Release everything, then a clean press and release on channel 0.
    ticks(4'h0, 12, 4);
    ticks(4'h1, 12, 4);
    chk("clean_press_level", lvl_a, 4'h1);
    ticks(4'h0, 12, 4);
    chk("clean_release_level", lvl_a, 4'h0);

    // Bounce on channel 1: 9 high ticks, 1 low tick, then held high.
    ticks(4'h2, 9, 4);
    chk("bounce_no_level", lvl_a, 4'h0);
    ticks(4'h0, 1, 4);
    ticks(4'h2, 9, 4);
    chk("bounce_still_low", lvl_a, 4'h0);
    ticks(4'h2, 3, 4);
    chk("bounce_level", lvl_a, 4'h2);
    ticks(4'h0, 12, 4);

    // No strobe for 1000 clocks while inputs toggle freely.
    for (int k = 0; k < 1000; k++) step(4'($urandom), 1'b0);
    chk("notick_level", lvl_a, 4'h0);
    ticks(4'h0, 12, 4);

    // Two channels pressed together.
    ticks(4'h5, 12, 3);
    chk("simul_level", lvl_a, 4'h5);
    // Reset in the middle of a release count.
    ticks(4'h0, 5, 3);
    async_reset(2);
    ticks(4'h0, 12, 3);
    chk("post_reset_quiet", lvl_a, 4'h0);
    // Reset in the middle of a press count; needs 10 fresh ticks afterwards.
    ticks(4'hA, 6, 3);
    async_reset(3);
    ticks(4'hA, 9, 3);
    chk("fresh_count_pending", lvl_a, 4'h0);
    ticks(4'hA, 2, 3);
    chk("fresh_count_done", lvl_a, 4'hA);

    // Random: slowly changing buttons with occasional bounce, random strobe.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      r = btn_raw;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 39) == 0) r[i] = ~r[i];
      step(r, ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Multi-channel push-button debouncer for the bop-it game, clocked by the system clock and sampling on the single-cycle 500 Hz strobe produced by the game's tick divider. Raw asynchronous button inputs are synchronized, filtered for a fixed number of consecutive stable ticks, and presented as clean levels plus single-cycle press/release pulses. The game FSM consumes these pulses directly.

## Interface

Parameters:
- NUM_BTN, default 4: number of independent button channels.
- STABLE_TICKS, default 10: consecutive agreeing ticks required to accept a change (20 ms at 500 Hz); legal range 1..255.
- CNT_W, derived as clog2(STABLE_TICKS+1): per-channel counter width; not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- clk_500hz  in  1  sample strobe; high for one clk cycle per sample period, synchronous to clk.
- btn_raw  in  NUM_BTN  raw button inputs, asynchronous, active-high.
- btn_level  out  NUM_BTN  debounced level per channel.
- btn_press  out  NUM_BTN  one-clk pulse on an accepted 0->1 transition.
- btn_release  out  NUM_BTN  one-clk pulse on an accepted 1->0 transition.

## Operation

- Per channel, btn_raw passes through a 2-flop synchronizer every clk; the second flop output is sync.
- Per channel, a counter cnt of CNT_W bits and the registered btn_level.
- On clk edges where clk_500hz=0: cnt and btn_level hold; no pulses.
- On clk edges where clk_500hz=1:
  - sync == btn_level: cnt <= 0 (bounce discards progress).
  - sync != btn_level and cnt == STABLE_TICKS-1: btn_level <= sync, cnt <= 0, assert btn_press (if sync=1) or btn_release (if sync=0) for exactly this one cycle.
  - sync != btn_level otherwise: cnt <= cnt+1.
- Each channel is a two-state machine (LOW, HIGH) with the counter as the qualifier; transitions happen only on the STABLE_TICKS-th consecutive disagreeing tick.
- Channels are fully independent; simultaneous accepted transitions on several channels pulse in the same cycle.
- cnt never exceeds STABLE_TICKS-1; no wrap-around is possible.
- STABLE_TICKS=1: a change is accepted on the first disagreeing tick.
- clk_500hz held high continuously (bench mode): behaves as sampling every clk; pulses remain one cycle wide because level has already flipped on the next edge.

## Timing

- Reset (rst_n=0, asynchronous): synchronizer flops, cnt, btn_level, btn_press, btn_release all 0 immediately. Reset mid-count discards progress; a button held during reset is reported as a press once accepted after release of reset.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency from a clean btn_raw edge: 2 clk (synchronizer), then acceptance on the STABLE_TICKS-th tick whose sampled sync reflects the new value; btn_level and pulse update on that same clk edge.
- A pulse never coincides with a non-tick cycle.

## Structure

- Shared package/include for the game: the 500 Hz tick rate constant and the default STABLE_TICKS value; no typedefs needed.
- One sub-module, debounce_channel (synchronizer, counter, level, pulse outputs for one bit), instantiated NUM_BTN times via generate in button_debouncer.

## Test plan

- Reset: hold rst_n=0 with btn_raw=4'hF -> all outputs 0; release reset, keep btn_raw=4'hF, ticks every 8 clk -> btn_press=4'hF pulses once on the 10th tick, btn_level=4'hF thereafter.
- Clean press: btn_raw[0] 0->1 and held -> btn_press[0] high exactly 1 clk on 10th tick after sync, btn_level[0]=1; release -> btn_release[0] after 10 ticks.
- Bounce: btn_raw[1] high for 9 ticks, low for 1 tick, then high -> no pulse until 10 further consecutive high ticks; exactly one btn_press[1].
- No tick: btn_raw toggles freely while clk_500hz=0 for 1000 clk -> outputs unchanged, cnt held.
- Simultaneous channels: btn_raw 4'b0000->4'b0101 at once -> btn_press=4'b0101 in the same cycle; mid-count assert rst_n=0 -> outputs 0 instantly, no pulse after release until 10 fresh ticks.
- STABLE_TICKS=1 with clk_500hz tied high -> btn_level follows btn_raw with 3-clk latency, one-clk pulse per edge.
